// File: rtl/and_unit_arbiter.sv
// Shares one registered W-bit AND unit among N requesters; 3-cycle grant/exec/ack sequence.
// Round-robin by default; define AND_ARB_FIXED_PRIO_EN for lowest-index-wins fixed priority.
module and_unit_arbiter #(
    parameter int N = 4,
    parameter int W = 8,
    localparam int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_i,
    input  logic [N*W-1:0]  a_i,
    input  logic [N*W-1:0]  b_i,
    output logic [N-1:0]    gnt_o,
    output logic [N-1:0]    ack_o,
    output logic [W-1:0]    res_o,
    output logic            res_valid_o,
    output logic [IW-1:0]   res_id_o,
    output logic            busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [W-1:0]    op_a;
    logic [W-1:0]    op_b;
    logic [W-1:0]    res_q;
    logic [IW-1:0]   gnt_id;
    logic [IW-1:0]   res_id_q;

    logic            win_vld;
    logic [IW-1:0]   win_id;

`ifdef AND_ARB_FIXED_PRIO_EN
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        for (int k = 0; k < N; k++) begin
            if (!win_vld && req_i[k]) begin
                win_vld = 1'b1;
                win_id  = IW'(k);
            end
        end
    end
`else
    logic [IW-1:0]   last;

    // Search upward from the requester after the last winner, wrapping at N-1.
    always_comb begin
        int idx;
        idx     = 0;
        win_vld = 1'b0;
        win_id  = '0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!win_vld && req_i[idx]) begin
                win_vld = 1'b1;
                win_id  = IW'(idx);
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        gnt_o       = '0;
        ack_o       = '0;
        res_valid_o = 1'b0;
        busy_o      = 1'b0;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                busy_o         = 1'b1;
                gnt_o[gnt_id]  = 1'b1;
                state_nxt      = DONE;
            end
            DONE: begin
                busy_o         = 1'b1;
                gnt_o[gnt_id]  = 1'b1;
                ack_o[gnt_id]  = 1'b1;
                res_valid_o    = 1'b1;
                state_nxt      = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Result and id registers only move at the end of EXEC, so they hold outside DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a     <= '0;
            op_b     <= '0;
            res_q    <= '0;
            gnt_id   <= '0;
            res_id_q <= '0;
`ifndef AND_ARB_FIXED_PRIO_EN
            last     <= IW'(N - 1);
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        op_a   <= a_i[int'(win_id)*W +: W];
                        op_b   <= b_i[int'(win_id)*W +: W];
                        gnt_id <= win_id;
                    end
                end
                EXEC: begin
                    res_q    <= op_a & op_b;
                    res_id_q <= gnt_id;
                end
                DONE: begin
`ifndef AND_ARB_FIXED_PRIO_EN
                    last <= gnt_id;
`endif
                end
                default: ;
            endcase
        end
    end

    assign res_o    = res_q;
    assign res_id_o = res_id_q;

endmodule

// File: tb/tb_and_unit_arbiter.sv
// Directed self-checking bench for and_unit_arbiter (N=4, W=8).
module tb_and_unit_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_i;
    logic [N*W-1:0] a_i;
    logic [N*W-1:0] b_i;
    logic [N-1:0]  gnt_o;
    logic [N-1:0]  ack_o;
    logic [W-1:0]  res_o;
    logic          res_valid_o;
    logic [1:0]    res_id_o;
    logic          busy_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    and_unit_arbiter #(.N(N), .W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .gnt_o       (gnt_o),
        .ack_o       (ack_o),
        .res_o       (res_o),
        .res_valid_o (res_valid_o),
        .res_id_o    (res_id_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Returns at the negedge of the first cycle with an ack, or ok=0 after lim cycles.
    task automatic wait_ack(input int lim, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (ack_o != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    logic         ok;
    int           prev_cyc;
    logic [1:0]   rr_order [5];
    logic [7:0]   rr_res   [4];

    initial begin
        rr_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rr_res   = '{8'h30, 8'h0C, 8'h3C, 8'h00};
        rst   = 1'b1;
        req_i = '0;
        a_i   = '0;
        b_i   = '0;
        tick; tick;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_gnt",   32'(gnt_o), 0);
        chk("rst_ack",   32'(ack_o), 0);
        chk("rst_res",   32'(res_o), 0);
        chk("rst_valid", 32'(res_valid_o), 0);
        chk("rst_id",    32'(res_id_o), 0);
        chk("rst_busy",  32'(busy_o), 0);

        // Single request: F0 & 3C = 30
        tick;
        req_i = 4'b0001;
        a_i[7:0] = 8'hF0;
        b_i[7:0] = 8'h3C;
        @(negedge clk);
        chk("s_idle_gnt", 32'(gnt_o), 0);
        tick;
        @(negedge clk);
        chk("s_exec_gnt", 32'(gnt_o), 32'b0001);
        chk("s_exec_ack", 32'(ack_o), 0);
        chk("s_exec_busy", 32'(busy_o), 1);
        tick;
        @(negedge clk);
        chk("s_done_gnt", 32'(gnt_o), 32'b0001);
        chk("s_done_ack", 32'(ack_o), 32'b0001);
        chk("s_done_res", 32'(res_o), 32'h30);
        chk("s_done_id",  32'(res_id_o), 0);
        chk("s_done_vld", 32'(res_valid_o), 1);
        tick;
        req_i = '0;
        @(negedge clk);
        chk("s_after_busy", 32'(busy_o), 0);
        chk("s_after_vld",  32'(res_valid_o), 0);
        chk("s_hold_res",   32'(res_o), 32'h30);

`ifndef AND_ARB_FIXED_PRIO_EN
        // Round-robin fairness from a fresh reset
        rst = 1'b1;
        tick;
        rst = 1'b0;
        a_i = {8'hC3, 8'hFF, 8'h0F, 8'hF0};
        b_i = {8'h3C, 8'h3C, 8'h3C, 8'h3C};
        req_i = 4'b1111;
        prev_cyc = 0;
        for (int t = 0; t < 5; t++) begin
            wait_ack(8, ok);
            chk("rr_ack_seen", 32'(ok), 1);
            if (!ok) break;
            chk("rr_ack", 32'(ack_o), 32'(1) << rr_order[t]);
            chk("rr_id",  32'(res_id_o), 32'(rr_order[t]));
            chk("rr_res", 32'(res_o), 32'(rr_res[rr_order[t]]));
            if (t > 0) chk("rr_spacing", 32'(cyc - prev_cyc), 3);
            prev_cyc = cyc;
            tick;
            if (t == 4) begin
                req_i = '0;
            end else begin
                req_i[rr_order[t]] = 1'b0;
                tick;
                req_i[rr_order[t]] = 1'b1;
            end
        end
        tick;
        @(negedge clk);
        chk("rr_end_busy", 32'(busy_o), 0);
`endif

        // Operand change after capture: FF & AA captured, a later forced to 00
        tick;
        req_i = 4'b0100;
        a_i[23:16] = 8'hFF;
        b_i[23:16] = 8'hAA;
        tick;
        a_i[23:16] = 8'h00;
        @(negedge clk);
        chk("op_exec_gnt", 32'(gnt_o), 32'b0100);
        tick;
        @(negedge clk);
        chk("op_ack", 32'(ack_o), 32'b0100);
        chk("op_res", 32'(res_o), 32'hAA);
        chk("op_id",  32'(res_id_o), 2);
        tick;
        req_i = '0;

        // Reset in EXEC: no ack, outputs cleared, pointer back to N-1
        tick;
        req_i = 4'b0010;
        a_i[15:8] = 8'hFF;
        b_i[15:8] = 8'hFF;
        tick;
        rst = 1'b1;
        @(negedge clk);
        chk("rm_exec_gnt", 32'(gnt_o), 32'b0010);
        tick;
        rst   = 1'b0;
        req_i = 4'b1011;
        @(negedge clk);
        chk("rm_ack",   32'(ack_o), 0);
        chk("rm_gnt",   32'(gnt_o), 0);
        chk("rm_busy",  32'(busy_o), 0);
        chk("rm_vld",   32'(res_valid_o), 0);
        chk("rm_res",   32'(res_o), 0);
        chk("rm_id",    32'(res_id_o), 0);
        tick;
        @(negedge clk);
        chk("rm_next_gnt", 32'(gnt_o), 32'b0001);
        tick;
        @(negedge clk);
        chk("rm_next_ack", 32'(ack_o), 32'b0001);
        tick;
        req_i = '0;

        // Withdrawn request: requester 1 drops during EXEC, 5A & 0F = 0A
        tick;
        req_i = 4'b0010;
        a_i[15:8] = 8'h5A;
        b_i[15:8] = 8'h0F;
        tick;
        req_i = '0;
        tick;
        @(negedge clk);
        chk("wd_ack", 32'(ack_o), 32'b0010);
        chk("wd_id",  32'(res_id_o), 1);
        chk("wd_res", 32'(res_o), 32'h0A);
        chk("wd_vld", 32'(res_valid_o), 1);
        tick;
        @(negedge clk);
        chk("wd_idle_busy", 32'(busy_o), 0);
        tick;
        @(negedge clk);
        chk("wd_stay_idle", 32'(busy_o), 0);

`ifdef AND_ARB_FIXED_PRIO_EN
        // Fixed priority: index 1 always wins over index 3
        req_i = 4'b1010;
        for (int t = 0; t < 4; t++) begin
            wait_ack(8, ok);
            chk("fp_ack_seen", 32'(ok), 1);
            if (!ok) break;
            chk("fp_ack", 32'(ack_o), 32'b0010);
            chk("fp_id",  32'(res_id_o), 1);
        end
        tick;
        req_i = '0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/and_unit_arbiter.md
# and_unit_arbiter

Shares one registered W-bit AND unit among N requesters: each requester presents operands and a request, the arbiter grants one at a time, computes `a & b`, and returns the result with a one-cycle acknowledge. The block sits between the requester clients and the bitwise-AND datapath, so each client does not need its own `and_logic` instance. Arbitration is round-robin by default; fixed priority is available as a compile-time option.

## Interface
- `N`, default 4: number of requesters. Must be at least 2.
- `W`, default 8: operand and result width.
- Derived: `IW = $clog2(N)`.

- `clk` — input, 1 bit. Single clock; all logic is on the rising edge.
- `rst` — input, 1 bit. Synchronous, active-high reset.
- `req_i` — input, N bits. Per-requester request level. Hold high until `ack_o[i]` is seen.
- `a_i` — input, N*W bits. Flattened operand A; requester i uses bits `[i*W +: W]`.
- `b_i` — input, N*W bits. Flattened operand B, same packing as `a_i`.
- `gnt_o` — output, N bits. One-hot grant, high while a requester's transaction is in flight.
- `ack_o` — output, N bits. One-hot, one-cycle completion pulse.
- `res_o` — output, W bits. Result (`a & b`) of the completed transaction.
- `res_valid_o` — output, 1 bit. High in the cycle `ack_o` pulses.
- `res_id_o` — output, IW bits. Index of the requester whose result is on `res_o`.
- `busy_o` — output, 1 bit. High in any state other than IDLE.

## Operation
- The FSM has three states: IDLE, EXEC, DONE.
- **IDLE:**
  - If `req_i` is nonzero, select a winner.
  - Latch `a_i` and `b_i` for the winner into `op_a`/`op_b`, store its index in `gnt_id`, set `gnt_o[gnt_id]`, and go to EXEC.
  - Otherwise remain in IDLE.
- **EXEC:**
  - `res_q <= op_a & op_b`, bitwise over W bits, with no width extension.
  - Go to DONE.
- **DONE:**
  - `ack_o[gnt_id]=1`, `res_valid_o=1`, `res_o=res_q`, `res_id_o=gnt_id`.
  - Update the round-robin pointer `last <= gnt_id`.
  - Clear `gnt_o` and go to IDLE.
- **Round-robin winner:** the first asserted `req_i` index searching upward from `last+1`, wrapping from N-1 to 0.
- **Operand capture:** operands are captured only in the IDLE selection cycle. Changes to `a_i`/`b_i` after that are ignored.
- **Request withdrawn during EXEC/DONE:** ignored. The transaction completes and `ack_o` still pulses.
- **Requester rule:** deassert `req_i[i]` on the clock edge that ends its `ack_o` cycle. A requester holding `req_i` high past the ack is treated as a new request in the next IDLE cycle.
- **New requests while busy:** not sampled. They wait and are arbitrated in the next IDLE cycle.

## Timing
- **Reset values:**
  - `gnt_o=0`, `ack_o=0`, `res_o=0`, `res_valid_o=0`, `res_id_o=0`, `busy_o=0`.
  - State is IDLE and `last=N-1`, so requester 0 has first priority.
- **Latency:** with `req_i` sampled high in IDLE at cycle t:
  - `gnt_o` is high in cycles t+1 and t+2.
  - `res_q` is written at the end of cycle t+1.
  - `ack_o`/`res_valid_o` are high in cycle t+2.
- **Throughput:** one transaction per 3 cycles under back-to-back requests. IDLE lasts exactly one cycle when any request is pending.
- `res_o` and `res_id_o` hold their last value outside DONE. They are meaningful only when `res_valid_o=1`.
- **Reset mid-transaction:** `rst` high in EXEC or DONE aborts the transaction. No `ack_o` is issued and all outputs return to reset values on the next edge.
- **Simultaneous requests:** exactly one grant per transaction. `gnt_o` and `ack_o` are never multi-hot.

## Configuration
- The macro `AND_ARB_FIXED_PRIO_EN` selects the arbitration policy.
- **Undefined (default):** round-robin as described above.
- **Defined:**
  - The winner is the lowest asserted index in `req_i`.
  - The `last` pointer register is not implemented.
  - Starvation of higher indices is allowed and is the intended behaviour.

## Test plan
- **Single request:** after reset, `req_i=4'b0001`, `a_i[7:0]=8'hF0`, `b_i[7:0]=8'h3C`.
  - Required: `gnt_o=4'b0001` for 2 cycles, then `ack_o=4'b0001` with `res_o=8'h30`, `res_id_o=0` at t+2, then `busy_o=0`.
- **Round-robin fairness:** all four requesters hold `req_i=4'b1111`, each dropping its request after its ack and re-raising it the next cycle.
  - Required: grant order 0,1,2,3,0,…, with acks spaced exactly 3 cycles apart.
- **Operand change after capture:** requester 2 changes `a_i` from 8'hFF to 8'h00 during EXEC, with `b_i=8'hAA`.
  - Required: `res_o=8'hAA`.
- **Reset mid-operation:** assert `rst` in EXEC.
  - Required: no `ack_o` pulse, all outputs zero next cycle, and the next transaction grants requester 0 first.
- **Withdrawn request:** requester 1 drops `req_i` during EXEC.
  - Required: `ack_o[1]` still pulses and `res_id_o=1`.
- **Fixed priority:** with `AND_ARB_FIXED_PRIO_EN` defined, `req_i=4'b1010` held continuously.
  - Required: every grant goes to index 1 and index 3 is never granted.
